// File: rtl/gat_feat_drain_if.sv
// Feature-drain bus bundle: GAT new-feature BRAM read port plus the outgoing valid/ready stream.
// With GAT_FEAT_ARGMAX_EN defined the per-node argmax result signals are added.
interface gat_feat_drain_if #(
  parameter int DATA_W      = 32,
  parameter int BYTE_ADDR_W = 16,
  parameter int NODE_W      = 12
`ifdef GAT_FEAT_ARGMAX_EN
  ,
  parameter int CLS_W       = 3
`endif
);
  logic [BYTE_ADDR_W-1:0] feat_bram_addrb;
  logic [DATA_W-1:0]      feat_bram_dout;
  logic [DATA_W-1:0]      m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;
  logic [NODE_W-1:0]      m_node_idx;
`ifdef GAT_FEAT_ARGMAX_EN
  logic [CLS_W-1:0]       cls_idx;
  logic                   cls_valid;
  logic [NODE_W-1:0]      cls_node_idx;
`endif

  modport master (
    output feat_bram_addrb,
    input  feat_bram_dout,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last,
    output m_node_idx
`ifdef GAT_FEAT_ARGMAX_EN
    ,
    output cls_idx,
    output cls_valid,
    output cls_node_idx
`endif
  );

  modport slave (
    input  feat_bram_addrb,
    output feat_bram_dout,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last,
    input  m_node_idx
`ifdef GAT_FEAT_ARGMAX_EN
    ,
    input  cls_idx,
    input  cls_valid,
    input  cls_node_idx
`endif
  );
endinterface

// File: rtl/gat_feat_drain.sv
// Drains the GAT new-feature BRAM (node-major) into a valid/ready stream with per-node last/index.
// Optional running signed argmax per node is enabled by defining GAT_FEAT_ARGMAX_EN.
module gat_feat_drain #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_NODES          = 2708,
  parameter int FEAT_PER_NODE      = 7,
  parameter int FEAT_DEPTH         = NUM_NODES * FEAT_PER_NODE,
  parameter int NEW_FEATURE_ADDR_W = $clog2(FEAT_DEPTH),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gat_ready,
  gat_feat_drain_if.master bus,
  output logic             busy,
  output logic             done
);
  localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int FEAT_W = (FEAT_PER_NODE > 1) ? $clog2(FEAT_PER_NODE) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_WORD = NEW_FEATURE_ADDR_W'(FEAT_DEPTH - 1);
  localparam logic [FEAT_W-1:0]             LAST_FEAT = FEAT_W'(FEAT_PER_NODE - 1);
  localparam logic [NODE_W-1:0]             LAST_NODE = NODE_W'(NUM_NODES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic                          gat_ready_q;
  logic [NEW_FEATURE_ADDR_W-1:0] word_q, word_d;
  logic [RD_LATENCY-1:0]         inflight_q, inflight_d;
  logic [NEW_FEATURE_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [FEAT_W-1:0]             feat_q, feat_d;
  logic [NODE_W-1:0]             node_q, node_d;

  logic                          start;
  logic                          issue;
  logic                          push;
  logic                          pop;
  logic                          fifo_empty;
  logic                          credit_ok;
  logic [CNT_W:0]                outstanding;

  // Credit = FIFO words plus reads still in the BRAM pipe; both must fit before a new read goes out.
  always_comb begin
    fifo_empty  = (count_q == '0);
    start       = gat_ready && !gat_ready_q;
    push        = inflight_q[RD_LATENCY-1];
    pop         = !fifo_empty && bus.m_ready;
    outstanding = (CNT_W+1)'(count_q) + (CNT_W+1)'($countones(inflight_q));
    credit_ok   = (outstanding < (CNT_W+1)'(FIFO_DEPTH));
    issue       = (state_q == S_ISSUE) && credit_ok;
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    word_d     = word_q;
    inflight_d = (inflight_q << 1) | RD_LATENCY'(issue);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    feat_d     = feat_q;
    node_d     = node_q;

    if (issue) begin
      word_d = (word_q == LAST_WORD) ? '0 : word_q + NEW_FEATURE_ADDR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (feat_q == LAST_FEAT) begin
        feat_d = '0;
        node_d = (node_q == LAST_NODE) ? '0 : node_q + NODE_W'(1);
      end else begin
        feat_d = feat_q + FEAT_W'(1);
      end
    end
  end

  // WAIT looks at post-update occupancy so DONE follows the cycle the last word is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (issue && (word_q == LAST_WORD)) state_d = S_WAIT;
      S_WAIT:  if ((count_d == '0) && (inflight_d == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    gat_ready_q <= gat_ready;
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      feat_q     <= '0;
      node_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      feat_q     <= feat_d;
      node_q     <= node_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.feat_bram_dout;
    end
  end

  assign bus.feat_bram_addrb = {word_q, 2'b00};
  assign bus.m_valid         = !fifo_empty;
  assign bus.m_data          = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign bus.m_last          = !fifo_empty && (feat_q == LAST_FEAT);
  assign bus.m_node_idx      = node_q;
  assign busy                = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done                = (state_q == S_DONE);

`ifdef GAT_FEAT_ARGMAX_EN
  logic [NEW_FEATURE_WIDTH-1:0] best_val_q, best_val_d;
  logic [FEAT_W-1:0]            best_idx_q, best_idx_d;
  logic [FEAT_W-1:0]            cls_idx_q, cls_idx_d;
  logic [NODE_W-1:0]            cls_node_q, cls_node_d;
  logic                         cls_valid_q, cls_valid_d;
  logic                         take;
  logic [FEAT_W-1:0]            cand_idx;

  // Strict greater-than keeps the lowest index on ties; feature 0 always seeds the node.
  always_comb begin
    take        = (feat_q == '0) || ($signed(bus.m_data) > $signed(best_val_q));
    cand_idx    = take ? feat_q : best_idx_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    cls_idx_d   = cls_idx_q;
    cls_node_d  = cls_node_q;
    cls_valid_d = 1'b0;
    if (pop) begin
      if (feat_q == LAST_FEAT) begin
        best_val_d  = '0;
        best_idx_d  = '0;
        cls_idx_d   = cand_idx;
        cls_node_d  = node_q;
        cls_valid_d = 1'b1;
      end else if (take) begin
        best_val_d = bus.m_data;
        best_idx_d = feat_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_val_q  <= '0;
      best_idx_q  <= '0;
      cls_idx_q   <= '0;
      cls_node_q  <= '0;
      cls_valid_q <= 1'b0;
    end else begin
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      cls_idx_q   <= cls_idx_d;
      cls_node_q  <= cls_node_d;
      cls_valid_q <= cls_valid_d;
    end
  end

  assign bus.cls_idx      = cls_idx_q;
  assign bus.cls_valid    = cls_valid_q;
  assign bus.cls_node_idx = cls_node_q;
`endif

endmodule

// File: doc/gat_feat_drain.md
Name: gat_feat_drain

Overview:
- Downstream consumer of the GAT top's new-feature BRAM read port; sits between `gat_top_wrapper` and the DMA/stream fabric.
- On the rising edge of `gat_ready` it walks every feature word (node-major, feature-minor) and issues word-aligned byte addresses on `feat_bram_addrb`.
- It absorbs the BRAM read latency and presents the words as a valid/ready stream with per-node `last`.
- A credit-based prefetch FIFO guarantees lossless backpressure.

Parameters:
- NEW_FEATURE_WIDTH, 32, width of one feature word (signed fixed-point).
- NUM_NODES, 2708, number of output nodes (subgraph roots) to drain.
- FEAT_PER_NODE, 7, features per node (final layer).
- FEAT_DEPTH, NUM_NODES*FEAT_PER_NODE, total words.
- NEW_FEATURE_ADDR_W, $clog2(FEAT_DEPTH), word-address width.
- RD_LATENCY, 2, BRAM addr-to-dout cycles (1..4).
- FIFO_DEPTH, 4, prefetch FIFO entries, power of two, must be >= RD_LATENCY+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- gat_ready  in  1  level from GAT top; a rising edge starts a drain.
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address = word_idx<<2; bits [1:0] are always 0.
- feat_bram_dout  in  NEW_FEATURE_WIDTH  BRAM read data, valid RD_LATENCY cycles after the address.
- m_data  out  NEW_FEATURE_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high on the last feature of each node.
- m_node_idx  out  $clog2(NUM_NODES)  node index of the current `m_data`.
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset:
  - All outputs 0; `feat_bram_addrb` = 0.
  - State = IDLE; FIFO empty; all counters 0; the in-flight read shift register is cleared, so reads issued before reset are discarded.
  - `gat_ready` edge detector register is loaded with the current `gat_ready`, so a level that is already high does not start a drain.
- Start condition: `gat_ready` high while the registered copy is low. Edges seen while busy are ignored. A new drain requires `gat_ready` to fall and rise again.
- FSM:
  - IDLE -> ISSUE on start.
  - ISSUE -> WAIT after the read for word FEAT_DEPTH-1 is issued.
  - WAIT -> DONE when the FIFO is empty and the in-flight count is 0.
  - DONE -> IDLE after 1 cycle; `done` pulses in the DONE cycle.
  - `busy` = (state != IDLE && state != DONE).
- Issue rule:
  - Read word k at cycle t only if occupancy + in_flight < FIFO_DEPTH (credit check).
  - The in-flight tag travels through an RD_LATENCY-deep valid shift register. At the end of that shift register, `feat_bram_dout` is written into the FIFO.
  - Sustained throughput: 1 word/cycle when `m_ready` stays high.
- Stream:
  - `m_valid` = FIFO not empty; `m_data` = FIFO head.
  - Data must be held stable while `m_valid && !m_ready`.
  - `m_last` and `m_node_idx` come from a pop-side feature counter (0..FEAT_PER_NODE-1) and node counter, both advanced on handshake.
  - Simultaneous push and pop is legal, and occupancy is unchanged.
- Boundaries:
  - The FIFO never overflows; the bench asserts this.
  - Pop on empty is impossible.
  - The feature counter wraps to 0 after FEAT_PER_NODE-1, and the node counter increments at the same time.
  - After the final node, all counters return to 0.
- `rst` asserted mid-drain: abort immediately, no `done` pulse, no stream beats on the following cycle.

Optional Feature:
- Macro: GAT_FEAT_ARGMAX_EN.
- With the macro defined, three extra outputs exist:
  - `cls_idx` [$clog2(FEAT_PER_NODE)-1:0].
  - `cls_valid` 1.
  - `cls_node_idx` [$clog2(NUM_NODES)-1:0].
- Argmax rules:
  - Running signed argmax over the accepted features of each node.
  - Ties keep the lowest index.
- Output timing:
  - `cls_valid` pulses for 1 cycle, the cycle after the handshake with `m_last`.
  - It includes the final feature.
  - The argmax registers reset to 0 per node and on `rst`.
- Without the macro: the ports and logic are absent, and stream behaviour is identical.

Test Plan:
- Basic drain (NUM_NODES=3, FEAT_PER_NODE=4, RD_LATENCY=2, BRAM word k = k+100), `m_ready`=1:
  - `feat_bram_addrb` steps 0,4,8,…,44.
  - 12 beats with data 100..111.
  - `m_last` on beats 3,7,11; `m_node_idx` 0,0,0,0,1,…,2.
  - `done` pulses once, 13+RD_LATENCY+1 cycles after start; `busy` is low after that.
- Backpressure: `m_ready` toggling 1,0,0,1 repeating:
  - Same 12 values in order, no duplicates or drops.
  - Outstanding (FIFO occupancy + in-flight reads) never exceeds 4; `m_data` stable during stalls.
- Level-high start: `gat_ready` high out of reset:
  - No drain.
  - Drop `gat_ready` for 1 cycle, then raise it: exactly one drain.
  - A second rising edge mid-drain is ignored.
- Reset mid-drain: assert `rst` after beat 5:
  - Next cycle `m_valid`=0, `busy`=0, `addrb`=0, no `done`.
  - A fresh edge restarts from word 0.
- GAT_FEAT_ARGMAX_EN, node 0 features {-5, 7, 7, 3}:
  - `cls_idx`=1 (tie keeps the lower index), `cls_node_idx`=0.
- GAT_FEAT_ARGMAX_EN, node 1 all negative {-9,-2,-8,-3}:
  - `cls_idx`=1.
  - Exactly one `cls_valid` pulse per node.
